// File: rtl/frame_ctrl.sv
// Pixel-array frame sequencer: erase -> expose -> convert -> read, with abort and frame counting.
// Optional continuous mode (input cont) is enabled by defining FRAME_CTRL_CONTINUOUS_EN.
module frame_ctrl #(
  parameter int unsigned PIXEL_COUNT = 4,
  parameter int unsigned EXP_W       = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           abort,
  input  logic [7:0]                     cfg_erase,
  input  logic [EXP_W-1:0]               cfg_expose,
  input  logic [7:0]                     cfg_convert,
  input  logic                           out_ready,
`ifdef FRAME_CTRL_CONTINUOUS_EN
  input  logic                           cont,
`endif
  output logic                           erase,
  output logic                           expose,
  output logic                           convert,
  output logic                           read,
  output logic [$clog2(PIXEL_COUNT)-1:0] pixel_select,
  output logic                           pix_valid,
  output logic                           busy,
  output logic                           frame_done,
  output logic [15:0]                    frame_cnt
);

  localparam int unsigned PW = $clog2(PIXEL_COUNT);
  localparam int unsigned CW = (EXP_W > 8) ? EXP_W : 8;
  localparam logic [PW-1:0] LAST_PIX = PW'(PIXEL_COUNT - 1);
  localparam logic [PW-1:0] PIX_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    EXPOSE,
    CONVERT,
    READ
  } state_t;

  state_t             state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [PW-1:0]      pix_n;
  logic               done_n;
  logic               cnt_up;
  logic               latch;
  logic               cont_i;
  logic [EXP_W-1:0]   sh_expose;
  logic [7:0]         sh_convert;

`ifdef FRAME_CTRL_CONTINUOUS_EN
  assign cont_i = cont;
`else
  assign cont_i = 1'b0;
`endif

  // Phase counter holds remaining cycles minus one; a zero length still yields one cycle.
  function automatic logic [CW-1:0] len_m1(input logic [CW-1:0] v);
    return (v == '0) ? '0 : v - CNT_ONE;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      pixel_select <= '0;
      frame_done   <= 1'b0;
      frame_cnt    <= '0;
      sh_expose    <= '0;
      sh_convert   <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      pixel_select <= pix_n;
      frame_done   <= done_n;
      if (cnt_up)
        frame_cnt <= frame_cnt + 16'd1;
      if (latch) begin
        sh_expose  <= cfg_expose;
        sh_convert <= cfg_convert;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pix_n   = pixel_select;
    done_n  = 1'b0;
    cnt_up  = 1'b0;
    latch   = 1'b0;
    if (abort && (state != IDLE)) begin
      state_n = IDLE;
      cnt_n   = '0;
      pix_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            latch   = 1'b1;
            state_n = ERASE;
            cnt_n   = len_m1(CW'(cfg_erase));
          end
        end
        ERASE: begin
          if (cnt == '0) begin
            state_n = EXPOSE;
            cnt_n   = len_m1(CW'(sh_expose));
          end else begin
            cnt_n = cnt - CNT_ONE;
          end
        end
        EXPOSE: begin
          if (cnt == '0) begin
            state_n = CONVERT;
            cnt_n   = len_m1(CW'(sh_convert));
          end else begin
            cnt_n = cnt - CNT_ONE;
          end
        end
        CONVERT: begin
          if (cnt == '0) begin
            state_n = READ;
            pix_n   = '0;
          end else begin
            cnt_n = cnt - CNT_ONE;
          end
        end
        READ: begin
          if (out_ready) begin
            if (pixel_select == LAST_PIX) begin
              done_n = 1'b1;
              cnt_up = 1'b1;
              pix_n  = '0;
              // Back-to-back frames re-latch configuration on the completing edge.
              if (cont_i) begin
                latch   = 1'b1;
                state_n = ERASE;
                cnt_n   = len_m1(CW'(cfg_erase));
              end else begin
                state_n = IDLE;
              end
            end else begin
              pix_n = pixel_select + PIX_ONE;
            end
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          pix_n   = '0;
        end
      endcase
    end
  end

  assign erase     = (state == ERASE);
  assign expose    = (state == EXPOSE);
  assign convert   = (state == CONVERT);
  assign read      = (state == READ);
  assign pix_valid = (state == READ);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_frame_ctrl.sv
// Randomized bench for frame_ctrl against a timeline-based reference model.
// Continuous-mode scenarios run only when FRAME_CTRL_CONTINUOUS_EN is defined.
module tb_frame_ctrl;

  localparam int unsigned PIXEL_COUNT = 4;
  localparam int unsigned EXP_W       = 16;
  localparam int unsigned PW          = $clog2(PIXEL_COUNT);
  localparam int          BOUND       = 3000;
`ifdef FRAME_CTRL_CONTINUOUS_EN
  localparam bit CONT_EN = 1'b1;
`else
  localparam bit CONT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [7:0]       cfg_erase;
  logic [EXP_W-1:0] cfg_expose;
  logic [7:0]       cfg_convert;
  logic             out_ready;
  logic             cont;
  logic             erase, expose, convert, read;
  logic [PW-1:0]    pixel_select;
  logic             pix_valid, busy, frame_done;
  logic [15:0]      frame_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: position in the frame timeline and handshakes completed.
  bit          m_active;
  bit          m_done;
  int          m_t, m_hs, m_e, m_x, m_c;
  int          m_frames;
  logic [15:0] m_cnt;

  int obs_busy, obs_read, obs_done, obs_idle;

  frame_ctrl #(.PIXEL_COUNT(PIXEL_COUNT), .EXP_W(EXP_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_erase(cfg_erase), .cfg_expose(cfg_expose), .cfg_convert(cfg_convert),
    .out_ready(out_ready),
`ifdef FRAME_CTRL_CONTINUOUS_EN
    .cont(cont),
`endif
    .erase(erase), .expose(expose), .convert(convert), .read(read),
    .pixel_select(pixel_select), .pix_valid(pix_valid), .busy(busy),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_latch();
    m_e  = (cfg_erase == 0) ? 1 : int'(cfg_erase);
    m_x  = (cfg_expose == 0) ? 1 : int'(cfg_expose);
    m_c  = (cfg_convert == 0) ? 1 : int'(cfg_convert);
    m_t  = 0;
    m_hs = 0;
  endtask

  function automatic int phase();
    if (!m_active)               return 0;
    if (m_t < m_e)               return 1;
    if (m_t < m_e + m_x)         return 2;
    if (m_t < m_e + m_x + m_c)   return 3;
    return 4;
  endfunction

  task automatic check_outputs();
    int ph = phase();
    check_eq("strobes",
             {25'b0, erase, expose, convert, read, pix_valid, busy, frame_done},
             {25'b0, ph == 1, ph == 2, ph == 3, ph == 4, ph == 4, m_active, m_done});
    check_eq("pixel_select", 32'(pixel_select), (ph == 4) ? 32'(m_hs) : 32'd0);
    check_eq("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
  endtask

  // Advance the model by the current inputs, clock once, then compare.
  task automatic step();
    bit cont_eff = CONT_EN ? cont : 1'b0;
    m_done = 1'b0;
    if (m_active) begin
      if (abort) begin
        m_active = 1'b0;
      end else if (phase() == 4 && out_ready) begin
        m_hs++;
        if (m_hs == PIXEL_COUNT) begin
          m_done = 1'b1;
          m_cnt  = m_cnt + 16'd1;
          m_frames++;
          if (cont_eff) model_latch();
          else          m_active = 1'b0;
        end
      end else begin
        m_t++;
      end
    end else if (start && !abort) begin
      model_latch();
      m_active = 1'b1;
    end
    @(posedge clk);
    #1;
    obs_busy += int'(busy);
    obs_read += int'(read);
    obs_done += int'(frame_done);
    obs_idle += int'(!busy);
    check_outputs();
  endtask

  task automatic clear_obs();
    obs_busy = 0; obs_read = 0; obs_done = 0; obs_idle = 0;
  endtask

  task automatic begin_frame(input int e, input int x, input int c);
    cfg_erase   = 8'(e);
    cfg_expose  = EXP_W'(x);
    cfg_convert = 8'(c);
    start = 1'b1;
    abort = 1'b0;
    step();
    start = 1'b0;
  endtask

  // ready_mode: 0 always ready, 1 random, 2 three-cycle stall at pixel 1.
  task automatic run_frame(input int ready_mode, input int abort_at,
                           input int cont_frames, input bit start_always);
    int cyc = 0;
    int stall_left = 3;
    int base = m_frames;
    while (m_active && cyc < BOUND) begin
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if (phase() == 4 && m_hs == 1 && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
      abort       = (cyc == abort_at);
      start       = start_always ? 1'b1 : ($urandom_range(0, 3) == 0);
      cont        = ((m_frames - base) < cont_frames);
      cfg_erase   = 8'($urandom_range(0, 6));
      cfg_expose  = EXP_W'($urandom_range(0, 6));
      cfg_convert = 8'($urandom_range(0, 6));
      step();
      cyc++;
    end
    if (m_active) check_eq("frame_bound", 32'(cyc), 32'(BOUND - 1));
    abort = 1'b0; start = 1'b0; cont = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1; cont = 1'b0;
    cfg_erase = '0; cfg_expose = '0; cfg_convert = '0;
    m_active = 1'b0; m_done = 1'b0; m_t = 0; m_hs = 0; m_e = 1; m_x = 1; m_c = 1;
    m_frames = 0; m_cnt = '0;
    clear_obs();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
    step();

    // Nominal 3/5/2 frame, always ready.
    clear_obs();
    begin_frame(3, 5, 2);
    run_frame(0, -1, 0, 1'b0);
    check_eq("nominal_busy_cycles", 32'(obs_busy), 32'd14);
    check_eq("nominal_read_cycles", 32'(obs_read), 32'd4);
    check_eq("nominal_done_pulses", 32'(obs_done), 32'd1);
    check_eq("nominal_frame_cnt", 32'(frame_cnt), 32'd1);
    step();

    // Stall for three cycles while pixel 1 is presented.
    clear_obs();
    begin_frame(1, 1, 1);
    run_frame(2, -1, 0, 1'b0);
    check_eq("stall_read_cycles", 32'(obs_read), 32'd7);

    // Abort in the second expose cycle.
    clear_obs();
    begin_frame(3, 5, 2);
    run_frame(0, 4, 0, 1'b0);
    check_eq("abort_done_pulses", 32'(obs_done), 32'd0);
    check_eq("abort_frame_cnt", 32'(frame_cnt), 32'd2);
    step();

    // Zero lengths give one-cycle phases; start held high throughout is ignored.
    clear_obs();
    begin_frame(0, 0, 0);
    run_frame(0, -1, 0, 1'b1);
    check_eq("zero_busy_cycles", 32'(obs_busy), 32'd7);
    step();

    // Abort coinciding with the last pixel handshake.
    clear_obs();
    begin_frame(0, 0, 0);
    run_frame(0, 6, 0, 1'b0);
    check_eq("abort_last_done", 32'(obs_done), 32'd0);

    // Start together with abort in IDLE is ignored.
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    step();

    // Long phases exercise the full counter widths.
    begin_frame(255, 300, 1);
    run_frame(1, -1, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      begin_frame($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6));
      run_frame(1, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 25)) : -1, 0, 1'b0);
      repeat ($urandom_range(0, 2)) step();
    end

    if (CONT_EN) begin
      clear_obs();
      begin_frame(2, 2, 2);
      run_frame(1, -1, 2, 1'b0);
      check_eq("cont_done_pulses", 32'(obs_done), 32'd3);
      check_eq("cont_idle_cycles", 32'(obs_idle), 32'd1);
      step();
    end

    // Counter wrap: preload close to the top, then complete two frames.
    force dut.frame_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.frame_cnt;
    m_cnt = 16'hFFFE;
    step();
    begin_frame(0, 0, 0);
    run_frame(0, -1, 0, 1'b0);
    check_eq("cnt_at_max", 32'(frame_cnt), 32'h0000FFFF);
    begin_frame(1, 0, 0);
    run_frame(1, -1, 0, 1'b0);
    check_eq("cnt_wrapped", 32'(frame_cnt), 32'd0);
    step();

    // Asynchronous reset in the middle of READ.
    begin_frame(0, 0, 0);
    out_ready = 1'b0;
    repeat (3) step();
    #2;
    reset = 1'b1;
    #1;
    m_active = 1'b0; m_done = 1'b0; m_hs = 0; m_t = 0; m_cnt = '0;
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
